// File: rtl/sdr_addr_pkg.sv
// Shared types, widths and helpers for the SDRAM request address splitter.
package sdr_addr_pkg;

    localparam int unsigned APP_AW     = 26;
    localparam int unsigned REQ_LENW   = 9;
    localparam int unsigned ROW_W      = 12;
    localparam int unsigned BANK_W     = 2;
    localparam int unsigned COL_W      = 12;
    // Page remainder needs up to 2^11, one size up from the widest column
    localparam int unsigned PAGE_REM_W = REQ_LENW + 3;

    typedef enum logic [1:0] {CB8, CB9, CB10, CB11} colbits_e;

    typedef enum logic {IDLE, ISSUE} state_e;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [BANK_W-1:0] bank;
        logic [COL_W-1:0]  col;
    } addr_fields_t;

    // Number of words in one SDRAM page for a given column width
    function automatic logic [PAGE_REM_W-1:0] page_words(colbits_e cb);
        logic [PAGE_REM_W-1:0] words;
        unique case (cb)
            CB8:     words = PAGE_REM_W'(256);
            CB9:     words = PAGE_REM_W'(512);
            CB10:    words = PAGE_REM_W'(1024);
            default: words = PAGE_REM_W'(2048);
        endcase
        return words;
    endfunction

endpackage

// File: rtl/sdr_req_addr_split_if.sv
// Application request port and bank-controller sub-request port.
interface sdr_req_addr_split_if;
    import sdr_addr_pkg::*;

    logic                app_req;
    logic [APP_AW-1:0]   app_req_addr;
    logic [REQ_LENW-1:0] app_req_len;
    logic                app_req_wr_n;
    logic                app_req_ack;
    logic                req_valid;
    logic                req_ack;
    logic [ROW_W-1:0]    req_row;
    logic [BANK_W-1:0]   req_bank;
    logic [COL_W-1:0]    req_col;
    logic [REQ_LENW-1:0] req_len;
    logic                req_wr_n;
    logic                req_last;
    logic                busy;

    // Environment side: application requester plus bank controller
    modport master (
        output app_req, app_req_addr, app_req_len, app_req_wr_n, req_ack,
        input  app_req_ack, req_valid, req_row, req_bank, req_col, req_len,
        input  req_wr_n, req_last, busy
    );

    // Splitter side
    modport slave (
        input  app_req, app_req_addr, app_req_len, app_req_wr_n, req_ack,
        output app_req_ack, req_valid, req_row, req_bank, req_col, req_len,
        output req_wr_n, req_last, busy
    );

endinterface

// File: rtl/sdr_addr_decode.sv
// Combinational split of a linear word address into row/bank/column, plus the
// number of words left in the current page from that column.
module sdr_addr_decode
    import sdr_addr_pkg::*;
(
    input  logic [APP_AW-1:0]     addr,
    input  colbits_e              cb,
    output addr_fields_t          fields,
    output logic [PAGE_REM_W-1:0] page_rem
);

    // Top address bit is never part of any decode
    logic unused_addr_msb;
    assign unused_addr_msb = addr[APP_AW-1];

    // Field extraction per column width
    always_comb begin
        fields = '0;
        unique case (cb)
            CB8: begin
                fields.col  = COL_W'(addr[7:0]);
                fields.bank = addr[9:8];
                fields.row  = addr[21:10];
            end
            CB9: begin
                fields.col  = COL_W'(addr[8:0]);
                fields.bank = addr[10:9];
                fields.row  = addr[22:11];
            end
            CB10: begin
                fields.col  = COL_W'(addr[9:0]);
                fields.bank = addr[11:10];
                fields.row  = addr[23:12];
            end
            default: begin
                fields.col  = COL_W'(addr[10:0]);
                fields.bank = addr[12:11];
                fields.row  = addr[24:13];
            end
        endcase
    end

    // Column is always below the page size, so this is 1..page_words
    assign page_rem = page_words(cb) - PAGE_REM_W'(fields.col);

endmodule

// File: rtl/sdr_req_addr_split.sv
// Request address generator: captures an application burst, decodes it into
// row/bank/column and splits it at page boundaries into sub-requests.
module sdr_req_addr_split
    import sdr_addr_pkg::*;
(
    input logic                 sdram_clk,
    input logic                 reset,
    input logic [1:0]           cfg_colbits,
    sdr_req_addr_split_if.slave bus
);

    state_e              state;
    logic [APP_AW-1:0]   addr_q;
    logic [REQ_LENW-1:0] rem_q;
    colbits_e            cb_q;

    logic                app_req_ack_q;
    logic                req_valid_q;
    addr_fields_t        fields_q;
    logic [REQ_LENW-1:0] req_len_q;
    logic                req_wr_n_q;
    logic                req_last_q;

    logic [APP_AW-1:0]     src_addr;
    logic [REQ_LENW-1:0]   src_rem;
    colbits_e              src_cb;
    addr_fields_t          src_fields;
    logic [PAGE_REM_W-1:0] src_page_rem;
    logic                  sub_last;
    logic [REQ_LENW-1:0]   sub_len;

    // Source of the next sub-request: fresh request in IDLE, advanced burst in ISSUE
    always_comb begin
        src_addr = addr_q;
        src_rem  = rem_q;
        src_cb   = cb_q;
        if (state == IDLE) begin
            src_addr = bus.app_req_addr;
            src_rem  = (bus.app_req_len == '0) ? REQ_LENW'(1) : bus.app_req_len;
            src_cb   = colbits_e'(cfg_colbits);
        end else begin
            // Wraps modulo 2^APP_AW by truncation
            src_addr = addr_q + APP_AW'(req_len_q);
            src_rem  = rem_q - req_len_q;
            src_cb   = cb_q;
        end
    end

    sdr_addr_decode u_decode (
        .addr     (src_addr),
        .cb       (src_cb),
        .fields   (src_fields),
        .page_rem (src_page_rem)
    );

    // When the page is shorter than the remainder it is below 2^REQ_LENW, so the slice is safe
    assign sub_last = (PAGE_REM_W'(src_rem) <= src_page_rem);
    assign sub_len  = sub_last ? src_rem : src_page_rem[REQ_LENW-1:0];

    // Control FSM with registered sub-request outputs
    always_ff @(posedge sdram_clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            addr_q        <= '0;
            rem_q         <= '0;
            cb_q          <= CB8;
            app_req_ack_q <= 1'b0;
            req_valid_q   <= 1'b0;
            fields_q      <= '0;
            req_len_q     <= '0;
            req_wr_n_q    <= 1'b1;
            req_last_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    app_req_ack_q <= 1'b0;
                    if (bus.app_req) begin
                        state         <= ISSUE;
                        addr_q        <= src_addr;
                        rem_q         <= src_rem;
                        cb_q          <= src_cb;
                        req_wr_n_q    <= bus.app_req_wr_n;
                        fields_q      <= src_fields;
                        req_len_q     <= sub_len;
                        req_last_q    <= sub_last;
                        req_valid_q   <= 1'b1;
                        app_req_ack_q <= 1'b1;
                    end
                end
                default: begin
                    app_req_ack_q <= 1'b0;
                    if (bus.req_ack) begin
                        if (req_last_q) begin
                            state       <= IDLE;
                            req_valid_q <= 1'b0;
                        end else begin
                            addr_q     <= src_addr;
                            rem_q      <= src_rem;
                            fields_q   <= src_fields;
                            req_len_q  <= sub_len;
                            req_last_q <= sub_last;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.app_req_ack = app_req_ack_q;
    assign bus.req_valid   = req_valid_q;
    assign bus.req_row     = fields_q.row;
    assign bus.req_bank    = fields_q.bank;
    assign bus.req_col     = fields_q.col;
    assign bus.req_len     = req_len_q;
    assign bus.req_wr_n    = req_wr_n_q;
    assign bus.req_last    = req_last_q;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_sdr_req_addr_split.sv
// Directed bench for sdr_req_addr_split with hand-computed sub-request fields.
module tb_sdr_req_addr_split;

    logic       sdram_clk = 1'b0;
    logic       reset;
    logic [1:0] cfg_colbits;

    int n_tests = 0;
    int n_fail  = 0;

    sdr_req_addr_split_if bus ();

    sdr_req_addr_split dut (
        .sdram_clk   (sdram_clk),
        .reset       (reset),
        .cfg_colbits (cfg_colbits),
        .bus         (bus)
    );

    always #5 sdram_clk = ~sdram_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sdram_clk);
        #1;
    endtask

    // Present a request for exactly one capture edge
    task automatic start_burst(input logic [1:0] cb, input logic [25:0] addr,
                               input logic [8:0] len, input logic wr_n);
        cfg_colbits      = cb;
        bus.app_req      = 1'b1;
        bus.app_req_addr = addr;
        bus.app_req_len  = len;
        bus.app_req_wr_n = wr_n;
        tick();
        bus.app_req = 1'b0;
    endtask

    task automatic expect_sub(input string tag, input logic [11:0] row, input logic [1:0] bank,
                              input logic [11:0] col, input logic [8:0] len, input logic last,
                              input logic wr_n);
        check({tag, ".valid"}, bus.req_valid, 1'b1);
        check({tag, ".row"},   bus.req_row,   row);
        check({tag, ".bank"},  bus.req_bank,  bank);
        check({tag, ".col"},   bus.req_col,   col);
        check({tag, ".len"},   bus.req_len,   len);
        check({tag, ".last"},  bus.req_last,  last);
        check({tag, ".wr_n"},  bus.req_wr_n,  wr_n);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".valid"}, bus.req_valid,   1'b0);
        check({tag, ".busy"},  bus.busy,        1'b0);
        check({tag, ".ack"},   bus.app_req_ack, 1'b0);
    endtask

    initial begin
        reset            = 1'b1;
        cfg_colbits      = 2'b00;
        bus.app_req      = 1'b0;
        bus.app_req_addr = '0;
        bus.app_req_len  = '0;
        bus.app_req_wr_n = 1'b1;
        bus.req_ack      = 1'b0;
        #2;
        expect_idle("rst");
        check("rst.wr_n", bus.req_wr_n, 1'b1);
        check("rst.len",  bus.req_len,  9'd0);
        check("rst.last", bus.req_last, 1'b0);
        check("rst.row",  bus.req_row,  12'd0);
        @(negedge sdram_clk);
        reset = 1'b0;
        tick();

        // 1: single sub-request inside one page
        start_burst(2'b00, 26'h1880, 9'd16, 1'b0);
        check("t1.ack",  bus.app_req_ack, 1'b1);
        check("t1.busy", bus.busy, 1'b1);
        expect_sub("t1.s1", 12'h006, 2'd0, 12'h080, 9'd16, 1'b1, 1'b0);
        bus.req_ack = 1'b1;
        tick();
        expect_idle("t1.end");
        bus.req_ack = 1'b0;

        // 2: page crossing under continuous req_ack
        bus.req_ack = 1'b1;
        start_burst(2'b00, 26'h1880, 9'd200, 1'b0);
        check("t2.ack", bus.app_req_ack, 1'b1);
        expect_sub("t2.s1", 12'd6, 2'd0, 12'h080, 9'd128, 1'b0, 1'b0);
        tick();
        check("t2.ackdrop", bus.app_req_ack, 1'b0);
        expect_sub("t2.s2", 12'd6, 2'd1, 12'h000, 9'd72, 1'b1, 1'b0);
        tick();
        expect_idle("t2.end");
        bus.req_ack = 1'b0;

        // 3: 11 column bits; a cfg change after capture must not matter
        start_burst(2'b11, 26'h77FE, 9'd4, 1'b1);
        cfg_colbits = 2'b00;
        expect_sub("t3.s1", 12'd3, 2'd2, 12'h7FE, 9'd2, 1'b0, 1'b1);
        bus.req_ack = 1'b1;
        tick();
        expect_sub("t3.s2", 12'd3, 2'd3, 12'h000, 9'd2, 1'b1, 1'b1);
        tick();
        expect_idle("t3.end");
        bus.req_ack = 1'b0;

        // 4: stall with a competing request held high
        start_burst(2'b00, 26'h1880, 9'd200, 1'b0);
        bus.app_req      = 1'b1;
        bus.app_req_addr = 26'h0123;
        bus.app_req_len  = 9'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4.noack", bus.app_req_ack, 1'b0);
            check("t4.busy",  bus.busy, 1'b1);
            expect_sub("t4.hold", 12'd6, 2'd0, 12'h080, 9'd128, 1'b0, 1'b0);
        end
        bus.app_req = 1'b0;
        bus.req_ack = 1'b1;
        tick();
        check("t4.noack2", bus.app_req_ack, 1'b0);
        expect_sub("t4.s2", 12'd6, 2'd1, 12'h000, 9'd72, 1'b1, 1'b0);
        tick();
        expect_idle("t4.end");
        bus.req_ack = 1'b0;

        // 5: address wrap at the top of the address space
        start_burst(2'b00, 26'h3FFFFFF, 9'd2, 1'b1);
        expect_sub("t5.s1", 12'hFFF, 2'd3, 12'h0FF, 9'd1, 1'b0, 1'b1);
        bus.req_ack = 1'b1;
        tick();
        expect_sub("t5.s2", 12'd0, 2'd0, 12'h000, 9'd1, 1'b1, 1'b1);
        tick();
        expect_idle("t5.end");
        bus.req_ack = 1'b0;

        // Zero length is treated as one word
        start_burst(2'b01, 26'h0010, 9'd0, 1'b0);
        expect_sub("len0", 12'd0, 2'd0, 12'h010, 9'd1, 1'b1, 1'b0);
        bus.req_ack = 1'b1;
        tick();
        expect_idle("len0.end");
        bus.req_ack = 1'b0;

        // 6: asynchronous reset during the second sub-request
        bus.req_ack = 1'b1;
        start_burst(2'b00, 26'h1880, 9'd200, 1'b0);
        tick();
        bus.req_ack = 1'b0;
        expect_sub("t6.s2", 12'd6, 2'd1, 12'h000, 9'd72, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        expect_idle("t6.rst");
        check("t6.rst.wr_n", bus.req_wr_n, 1'b1);
        @(negedge sdram_clk);
        reset = 1'b0;
        start_burst(2'b00, 26'h0004, 9'd2, 1'b1);
        check("t6.ack", bus.app_req_ack, 1'b1);
        expect_sub("t6.new", 12'd0, 2'd0, 12'h004, 9'd2, 1'b1, 1'b1);
        tick();
        check("t6.ackdrop", bus.app_req_ack, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
